bsh_arb_2: RTL and testbench

- Two-requester round-robin scheduler that shares one 32-bit barrel rotator between two clients.
- The rotator is combinational: dir=0 rotates left by sh, dir=1 rotates right by sh, implemented as a left rotate by (32−sh) mod 32.
- This block adds valid/ready request and response handshakes, per-request op decode (rotate, logical shift, arithmetic shift) with masking, and a single registered result slot.
- It sits between the integer issue logic and the shifter datapath.

---
 rtl/bsh_arb_2.sv | 129 ++++++++++++
 tb/tb_bsh_arb_2.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsh_arb_2.sv
// Two-port round-robin front end for a shared 32-bit barrel rotator.
// Handles request/response handshakes, op decode with masking, and one registered result slot.
module bsh_arb_2 #(
    parameter bit          RR_INIT = 1'b0,
    parameter int unsigned SH_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_data,
    input  logic            req0_dir,
    input  logic [SH_W-1:0] req0_sh,
    input  logic [1:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_data,
    input  logic            req1_dir,
    input  logic [SH_W-1:0] req1_sh,
    input  logic [1:0]      req1_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [31:0]     rsp0_data,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [31:0]     rsp1_data,
    output logic            busy,
    output logic            prio
);

    // Handshake rule: a transfer happens on any rising edge where valid & ready
    // are both high; ready never looks at its own port's valid.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    slot_state_e state_q, state_d;
    logic        res_owner_q, res_owner_d;
    logic [31:0] res_data_q, res_data_d;
    logic        prio_q, prio_d;

    logic            res_valid;
    logic            owner_ready;
    logic            can_accept;
    logic            hs0, hs1, hs;
    logic [31:0]     sel_data;
    logic            sel_dir;
    logic [SH_W-1:0] sel_sh;
    logic [1:0]      sel_op;
    logic [SH_W-1:0] rot_amt;
    logic [63:0]     rot_wide;
    logic [31:0]     rot;
    logic [31:0]     mask_l;
    logic [31:0]     mask_r;
    logic [31:0]     result;

    assign res_valid   = (state_q == S_FULL);
    assign owner_ready = res_owner_q ? rsp1_ready : rsp0_ready;
    assign can_accept  = !res_valid || owner_ready;

    assign req0_ready = can_accept && (!prio_q || !req1_valid);
    assign req1_ready = can_accept && (prio_q || !req0_valid);
    assign hs0 = req0_valid && req0_ready;
    assign hs1 = req1_valid && req1_ready;
    assign hs  = hs0 || hs1;

    always_comb begin
        sel_data = hs1 ? req1_data : req0_data;
        sel_dir  = hs1 ? req1_dir  : req0_dir;
        sel_sh   = hs1 ? req1_sh   : req0_sh;
        sel_op   = hs1 ? req1_op   : req0_op;
        // A right rotate is a left rotate by the negated amount, which wraps to 0 for sh=0.
        rot_amt  = sel_dir ? (~sel_sh + SH_W'(1)) : sel_sh;
        rot_wide = {sel_data, sel_data} << rot_amt;
        rot      = rot_wide[63:32];
        mask_l   = 32'hFFFF_FFFF << sel_sh;
        mask_r   = 32'hFFFF_FFFF >> sel_sh;
        result   = rot;
        case (sel_op)
            2'b01:   result = sel_dir ? (rot & mask_r) : (rot & mask_l);
            2'b10:   result = sel_dir ? ((rot & mask_r) | (sel_data[31] ? ~mask_r : 32'h0))
                                      : (rot & mask_l);
            default: result = rot;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        res_owner_d = res_owner_q;
        res_data_d  = res_data_q;
        prio_d      = prio_q;
        case (state_q)
            S_EMPTY: if (hs) state_d = S_FULL;
            S_FULL: begin
                if (hs)               state_d = S_FULL;
                else if (owner_ready) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
        if (hs) begin
            res_owner_d = hs1;
            res_data_d  = result;
            prio_d      = hs0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            res_owner_q <= 1'b0;
            res_data_q  <= 32'h0;
            prio_q      <= RR_INIT;
        end else begin
            state_q     <= state_d;
            res_owner_q <= res_owner_d;
            res_data_q  <= res_data_d;
            prio_q      <= prio_d;
        end
    end

    assign rsp0_valid = res_valid && !res_owner_q;
    assign rsp1_valid = res_valid && res_owner_q;
    assign rsp0_data  = res_data_q;
    assign rsp1_data  = res_data_q;
    assign busy       = res_valid;
    assign prio       = prio_q;

endmodule

// File: tb/tb_bsh_arb_2.sv
// Bench for bsh_arb_2: directed scenarios plus randomized traffic against a
// transaction-level model (slot occupancy, owner, priority, expected-result queue).
module tb_bsh_arb_2;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic [31:0] req_data  [2];
    logic        req_dir   [2];
    logic [4:0]  req_sh    [2];
    logic [1:0]  req_op    [2];
    logic        rsp_ready [2];
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        busy, prio;

    int n_checks = 0;
    int n_fail   = 0;

    logic        m_valid;
    logic        m_owner;
    logic        m_prio;
    logic [31:0] exp_q [$];

    bsh_arb_2 #(.RR_INIT(1'b0), .SH_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req_valid[0]),
        .req0_ready (req0_ready),
        .req0_data  (req_data[0]),
        .req0_dir   (req_dir[0]),
        .req0_sh    (req_sh[0]),
        .req0_op    (req_op[0]),
        .req1_valid (req_valid[1]),
        .req1_ready (req1_ready),
        .req1_data  (req_data[1]),
        .req1_dir   (req_dir[1]),
        .req1_sh    (req_sh[1]),
        .req1_op    (req_op[1]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp_ready[0]),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp_ready[1]),
        .rsp1_data  (rsp1_data),
        .busy       (busy),
        .prio       (prio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference semantics written directly with word-level shift operators.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic dir,
                                              input logic [4:0] sh, input logic [1:0] op);
        int s;
        s = int'(sh);
        if (s == 0) return d;
        case (op)
            2'b01:   return dir ? (d >> s) : (d << s);
            2'b10:   return dir ? 32'($signed(d) >>> s) : (d << s);
            default: return dir ? ((d >> s) | (d << (32 - s))) : ((d << s) | (d >> (32 - s)));
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_owner = 1'b0;
        m_prio  = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive_req(input int p, input logic v, input logic [31:0] d,
                             input logic dir, input logic [4:0] sh, input logic [1:0] op);
        req_valid[p] = v;
        req_data[p]  = d;
        req_dir[p]   = dir;
        req_sh[p]    = sh;
        req_op[p]    = op;
    endtask

    // One clock: check everything against the model at the falling edge, advance the model.
    task automatic step();
        logic rr, can;
        logic rdy [2];
        @(negedge clk);
        rr     = rsp_ready[m_owner];
        can    = !m_valid || rr;
        rdy[0] = can && (m_prio == 1'b0 || !req_valid[1]);
        rdy[1] = can && (m_prio == 1'b1 || !req_valid[0]);
        chk("busy", 32'(busy), 32'(m_valid));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(m_valid && !m_owner));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(m_valid && m_owner));
        chk("prio", 32'(prio), 32'(m_prio));
        chk("req0_ready", 32'(req0_ready), 32'(rdy[0]));
        chk("req1_ready", 32'(req1_ready), 32'(rdy[1]));
        if (m_valid && exp_q.size() > 0) begin
            chk("rsp0_data", rsp0_data, exp_q[0]);
            chk("rsp1_data", rsp1_data, exp_q[0]);
        end
        if (m_valid && rr) begin
            void'(exp_q.pop_front());
            m_valid = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && rdy[i]) begin
                exp_q.push_back(ref_shift(req_data[i], req_dir[i], req_sh[i], req_op[i]));
                m_valid = 1'b1;
                m_owner = 1'(i);
                m_prio  = (i == 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] d;
        logic        dir;
        logic [4:0]  sh;
        logic [1:0]  op;
        logic [31:0] exp;
    } op_vec_t;

    op_vec_t vecs [9];

    initial begin
        vecs[0] = '{32'h8000_0000, 1'b1, 5'd4, 2'b10, 32'hF800_0000};
        vecs[1] = '{32'h8000_0000, 1'b1, 5'd4, 2'b01, 32'h0800_0000};
        vecs[2] = '{32'h0000_000F, 1'b0, 5'd4, 2'b01, 32'h0000_00F0};
        vecs[3] = '{32'h0000_0001, 1'b1, 5'd1, 2'b00, 32'h8000_0000};
        vecs[4] = '{32'h8765_4321, 1'b1, 5'd0, 2'b00, 32'h8765_4321};
        vecs[5] = '{32'h8765_4321, 1'b0, 5'd0, 2'b01, 32'h8765_4321};
        vecs[6] = '{32'h8765_4321, 1'b1, 5'd0, 2'b10, 32'h8765_4321};
        vecs[7] = '{32'h8765_4321, 1'b1, 5'd0, 2'b11, 32'h8765_4321};
        vecs[8] = '{32'h0000_00F1, 1'b0, 5'd4, 2'b10, 32'h0000_0F10};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_req(i, 1'b0, 32'h0, 1'b0, 5'd0, 2'b00);
            rsp_ready[i] = 1'b1;
        end
        model_reset();
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("reset_rsp_data", rsp0_data, 32'h0);
        chk("reset_prio", 32'(prio), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Port 0 alone, rotate left by one.
        drive_req(0, 1'b1, 32'h8000_0001, 1'b0, 5'd1, 2'b00);
        step();
        drive_req(0, 1'b0, 32'hDEAD_BEEF, 1'b1, 5'd7, 2'b10);
        chk("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("t1_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("t1_rsp0_data", rsp0_data, 32'h0000_0003);
        step();

        // Op sweep on port 1, one request per cycle.
        for (int k = 0; k < 9; k++) begin
            drive_req(1, 1'b1, vecs[k].d, vecs[k].dir, vecs[k].sh, vecs[k].op);
            step();
            chk($sformatf("t2_op%0d_data", k), rsp1_data, vecs[k].exp);
            chk($sformatf("t2_op%0d_valid", k), 32'(rsp1_valid), 32'd1);
        end
        drive_req(1, 1'b0, 32'h0, 1'b0, 5'd0, 2'b00);

        // Both ports streaming: grants alternate starting with port 0.
        for (int k = 0; k < 4; k++) begin
            drive_req(0, 1'b1, 32'h1000 + 32'(k), 1'b0, 5'(k), 2'b00);
            drive_req(1, 1'b1, 32'h2000 + 32'(k), 1'b1, 5'(k), 2'b01);
            step();
            chk($sformatf("t3_rsp0_valid%0d", k), 32'(rsp0_valid), 32'(k % 2 == 0));
            chk($sformatf("t3_rsp1_valid%0d", k), 32'(rsp1_valid), 32'(k % 2 == 1));
            chk($sformatf("t3_prio%0d", k), 32'(prio), 32'(k % 2 == 0));
        end

        // Backpressure on a port 0 result.
        rsp_ready[0] = 1'b0;
        drive_req(0, 1'b1, 32'h1234_5678, 1'b0, 5'd4, 2'b00);
        drive_req(1, 1'b1, 32'h0000_00FF, 1'b0, 5'd8, 2'b01);
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_req0_ready%0d", k), 32'(req0_ready), 32'd0);
            chk($sformatf("t4_req1_ready%0d", k), 32'(req1_ready), 32'd0);
            chk($sformatf("t4_hold%0d", k), rsp0_data, 32'h2345_6781);
            step();
        end
        rsp_ready[0] = 1'b1;
        #1;
        chk("t4_release_req1_ready", 32'(req1_ready), 32'd1);
        chk("t4_release_req0_ready", 32'(req0_ready), 32'd0);
        step();
        chk("t4_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("t4_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("t4_rsp1_data", rsp1_data, 32'h0000_FF00);

        // Asynchronous reset while a port 1 result is held.
        rsp_ready[1] = 1'b0;
        drive_req(0, 1'b0, 32'h0, 1'b0, 5'd0, 2'b00);
        drive_req(1, 1'b0, 32'h0, 1'b0, 5'd0, 2'b00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_prio", 32'(prio), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rsp_ready[1] = 1'b1;
        step();
        chk("t5_no_stale0", 32'(rsp0_valid), 32'd0);
        chk("t5_no_stale1", 32'(rsp1_valid), 32'd0);

        // Lone requester while the other port holds priority.
        drive_req(0, 1'b1, 32'hA5A5_0000, 1'b0, 5'd3, 2'b01);
        step();
        drive_req(0, 1'b0, 32'h0, 1'b0, 5'd0, 2'b00);
        step();
        step();
        chk("t6_prio_before", 32'(prio), 32'd1);
        drive_req(0, 1'b1, 32'h0000_0F00, 1'b1, 5'd8, 2'b10);
        #1;
        chk("t6_req0_ready", 32'(req0_ready), 32'd1);
        step();
        chk("t6_prio_after", 32'(prio), 32'd1);
        chk("t6_rsp0_data", rsp0_data, 32'h0000_000F);
        drive_req(0, 1'b0, 32'h0, 1'b0, 5'd0, 2'b00);
        step();

        // Random traffic; inputs behind a low valid are random garbage.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                drive_req(i, 1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
                rsp_ready[i] = 1'($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
